// File: rtl/vend_ctrl.sv
// Vending-machine credit sequencer: conditions front-panel levels into events,
// holds the balance and runs the dispense and change-return sequences.
module vend_ctrl #(
   parameter int PRICE_ONE   = 2,
   parameter int PRICE_TWO   = 5,
   parameter int MAX_BAL     = 999,
   parameter int VEND_CYCLES = 4,
   parameter int PULSE_GAP   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       coin_one,
   input  logic       coin_ten,
   input  logic       buy_one,
   input  logic       buy_two,
   input  logic       get_ind,
   input  logic       cancle_flag,
   output logic [9:0] coin_val,
   output logic       buy_flag,
   output logic       disp_one,
   output logic       disp_two,
   output logic       chg_ten,
   output logic       chg_one,
   output logic       coin_rej,
   output logic       short_err,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, VEND = 2'd1, CHANGE = 2'd2} state_t;

   localparam logic [10:0] MAX_W     = 11'(MAX_BAL);
   localparam logic [9:0]  P1        = 10'(PRICE_ONE);
   localparam logic [9:0]  P2        = 10'(PRICE_TWO);
   localparam logic [7:0]  VEND_LAST = 8'(VEND_CYCLES - 1);
   localparam logic [7:0]  GAP_LEN   = 8'(PULSE_GAP);

   function automatic logic fits(input logic [9:0] bal, input logic [9:0] amt);
      fits = (({1'b0, bal} + {1'b0, amt}) <= MAX_W);
   endfunction

   // bit order follows service priority, highest at the top
   logic [5:0] raw_s;
   logic [5:0] sync1_r, sync2_r, sync3_r, evt_r;
   state_t     state_r, state_s;
   logic [9:0] coin_s;
   logic [7:0] cnt_r, cnt_s;
   logic       disp1_s, disp2_s, buy_s, chg10_s, chg1_s, rej_s, short_s;

   assign raw_s = {cancle_flag, get_ind, buy_two, buy_one, coin_ten, coin_one};

   // Two-flop synchronizer plus registered rising-edge detector
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_r <= 6'd0;
         sync2_r <= 6'd0;
         sync3_r <= 6'd0;
         evt_r   <= 6'd0;
      end else begin
         sync1_r <= raw_s;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
         evt_r   <= sync2_r & ~sync3_r;
      end
   end

   // Next-state, balance and output decode; cnt_r times both dispense and gaps
   always_comb begin
      state_s = state_r;
      coin_s  = coin_val;
      cnt_s   = cnt_r;
      disp1_s = disp_one;
      disp2_s = disp_two;
      buy_s   = 1'b0;
      chg10_s = 1'b0;
      chg1_s  = 1'b0;
      rej_s   = 1'b0;
      short_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (evt_r[5] || evt_r[4]) begin
               if (coin_val != 10'd0) begin
                  state_s = CHANGE;
                  cnt_s   = 8'd0;
               end else begin
                  state_s = IDLE;
               end
            end else if (evt_r[3]) begin
               if (coin_val >= P2) begin
                  coin_s  = coin_val - P2;
                  buy_s   = 1'b1;
                  disp2_s = 1'b1;
                  cnt_s   = VEND_LAST;
                  state_s = VEND;
               end else begin
                  short_s = 1'b1;
               end
            end else if (evt_r[2]) begin
               if (coin_val >= P1) begin
                  coin_s  = coin_val - P1;
                  buy_s   = 1'b1;
                  disp1_s = 1'b1;
                  cnt_s   = VEND_LAST;
                  state_s = VEND;
               end else begin
                  short_s = 1'b1;
               end
            end else if (evt_r[1]) begin
               if (fits(coin_val, 10'd10)) begin
                  coin_s = coin_val + 10'd10;
               end else begin
                  rej_s = 1'b1;
               end
            end else if (evt_r[0]) begin
               if (fits(coin_val, 10'd1)) begin
                  coin_s = coin_val + 10'd1;
               end else begin
                  rej_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         VEND: begin
            if (cnt_r == 8'd0) begin
               disp1_s = 1'b0;
               disp2_s = 1'b0;
               state_s = IDLE;
            end else begin
               cnt_s = cnt_r - 8'd1;
            end
         end
         CHANGE: begin
            if (cnt_r != 8'd0) begin
               cnt_s = cnt_r - 8'd1;
            end else if (coin_val >= 10'd10) begin
               coin_s  = coin_val - 10'd10;
               chg10_s = 1'b1;
               cnt_s   = GAP_LEN;
            end else if (coin_val != 10'd0) begin
               coin_s = coin_val - 10'd1;
               chg1_s = 1'b1;
               cnt_s  = GAP_LEN;
            end else begin
               state_s = IDLE;
            end
         end
         default: begin
            state_s = IDLE;
            disp1_s = 1'b0;
            disp2_s = 1'b0;
            cnt_s   = 8'd0;
         end
      endcase
   end

   // State, balance and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= IDLE;
         cnt_r     <= 8'd0;
         coin_val  <= 10'd0;
         buy_flag  <= 1'b0;
         disp_one  <= 1'b0;
         disp_two  <= 1'b0;
         chg_ten   <= 1'b0;
         chg_one   <= 1'b0;
         coin_rej  <= 1'b0;
         short_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         coin_val  <= coin_s;
         buy_flag  <= buy_s;
         disp_one  <= disp1_s;
         disp_two  <= disp2_s;
         chg_ten   <= chg10_s;
         chg_one   <= chg1_s;
         coin_rej  <= rej_s;
         short_err <= short_s;
         busy      <= (state_s != IDLE);
      end
   end

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: stimulus queues expected output events,
// a negedge monitor pops and compares each event the DUT presents.
module tb_vend_ctrl;

   localparam int K_COIN = 0, K_BUY = 1, K_CHG10 = 2, K_CHG1 = 3, K_REJ = 4,
                  K_SHORT = 5, K_DISP1 = 6, K_DISP2 = 7, K_IDLE = 8;

   typedef struct packed {
      logic [3:0]  kind;
      logic [15:0] val;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] in_vec;
   logic [9:0] coin_val;
   logic       buy_flag, disp_one, disp_two, chg_ten, chg_one, coin_rej, short_err, busy;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   vend_ctrl dut (
      .clk(clk), .reset(reset),
      .coin_one(in_vec[0]), .coin_ten(in_vec[1]), .buy_one(in_vec[2]),
      .buy_two(in_vec[3]), .get_ind(in_vec[4]), .cancle_flag(in_vec[5]),
      .coin_val(coin_val), .buy_flag(buy_flag), .disp_one(disp_one), .disp_two(disp_two),
      .chg_ten(chg_ten), .chg_one(chg_one), .coin_rej(coin_rej), .short_err(short_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic string kname(input int k);
      case (k)
         K_COIN:  kname = "coin_val";
         K_BUY:   kname = "buy_flag";
         K_CHG10: kname = "chg_ten";
         K_CHG1:  kname = "chg_one";
         K_REJ:   kname = "coin_rej";
         K_SHORT: kname = "short_err";
         K_DISP1: kname = "disp_one_len";
         K_DISP2: kname = "disp_two_len";
         K_IDLE:  kname = "busy_fall";
         default: kname = "unknown";
      endcase
   endfunction

   task automatic push(input int k, input int v);
      exp_t e;
      e.kind = 4'(k);
      e.val  = 16'(v);
      q.push_back(e);
   endtask

   task automatic got(input int k, input int v);
      exp_t e;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event %s actual=%0d required=none", kname(k), v);
      end else begin
         e = q.pop_front();
         if (e.kind != 4'(k) || e.val != 16'(v)) begin
            errors++;
            $display("FAIL event actual=%s/%0d required=%s/%0d", kname(k), v,
                     kname(int'(e.kind)), int'(e.val));
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: cycle distances for change pulses / busy fall, run length for dispense
   initial begin
      int cyc = 0, mark = 0, run1 = 0, run2 = 0;
      logic [9:0] p_coin = 10'd0;
      logic p_busy = 1'b0, p_d1 = 1'b0, p_d2 = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            p_coin = 10'd0; p_busy = 1'b0; p_d1 = 1'b0; p_d2 = 1'b0;
            run1 = 0; run2 = 0;
         end else begin
            cyc++;
            if (busy && !p_busy) mark = cyc;
            if (coin_val != p_coin) got(K_COIN, int'(coin_val));
            if (buy_flag) got(K_BUY, int'(coin_val));
            if (chg_ten) begin got(K_CHG10, cyc - mark); mark = cyc; end
            if (chg_one) begin got(K_CHG1, cyc - mark); mark = cyc; end
            if (coin_rej) got(K_REJ, int'(coin_val));
            if (short_err) got(K_SHORT, int'(coin_val));
            if (disp_one) run1++;
            else if (p_d1) begin got(K_DISP1, run1); run1 = 0; end
            if (disp_two) run2++;
            else if (p_d2) begin got(K_DISP2, run2); run2 = 0; end
            if (!busy && p_busy) got(K_IDLE, cyc - mark);
            p_coin = coin_val; p_busy = busy; p_d1 = disp_one; p_d2 = disp_two;
         end
      end
   end

   task automatic press(input int b, input int hold, input int low);
      @(negedge clk);
      in_vec[b] = 1'b1;
      repeat (hold) @(negedge clk);
      in_vec[b] = 1'b0;
      repeat (low) @(negedge clk);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (q.size() == 0) break;
         @(posedge clk);
         #2;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", q.size());
         q.delete();
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_out(input int which, input string name);
      bit found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if ((which == 0 && disp_one) || (which == 1 && chg_ten)) begin
            found = 1'b1;
            break;
         end
      end
      chk(name, int'(found), 1);
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_coin"}, int'(coin_val), 0);
      chk({name, "_outs"}, int'({busy, disp_one, disp_two, buy_flag, chg_ten, chg_one,
                                 coin_rej, short_err}), 0);
   endtask

   task automatic mid_reset(input string name);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs(name);
      in_vec = 6'd0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset  = 1'b0;
      in_vec = 6'd0;
      #1;
      check_reset_outputs("por");
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // coins 1,2,3 then +10
      for (int i = 1; i <= 3; i++) begin
         push(K_COIN, i);
         press(0, 4, 4);
      end
      push(K_COIN, 13);
      press(1, 4, 4);
      drain(50);

      // purchases, then an under-funded request
      push(K_COIN, 8); push(K_BUY, 8); push(K_DISP2, 4); push(K_IDLE, 4);
      press(3, 4, 4);
      push(K_COIN, 3); push(K_BUY, 3); push(K_DISP2, 4); push(K_IDLE, 4);
      press(3, 4, 4);
      push(K_COIN, 1); push(K_BUY, 1); push(K_DISP1, 4); push(K_IDLE, 4);
      press(2, 4, 4);
      push(K_SHORT, 1);
      press(3, 4, 4);
      drain(50);

      // build 23 and return change
      push(K_COIN, 11); press(1, 2, 2);
      push(K_COIN, 21); press(1, 2, 2);
      push(K_COIN, 22); press(0, 2, 2);
      push(K_COIN, 23); press(0, 2, 2);
      push(K_COIN, 13); push(K_CHG10, 1);
      push(K_COIN, 3);  push(K_CHG10, 3);
      for (int j = 2; j >= 0; j--) begin
         push(K_COIN, j);
         push(K_CHG1, 3);
      end
      push(K_IDLE, 3);
      press(4, 4, 4);
      drain(100);

      // fill to the ceiling
      for (int i = 1; i <= 99; i++) begin
         push(K_COIN, i * 10);
         press(1, 2, 2);
      end
      for (int i = 991; i <= 995; i++) begin
         push(K_COIN, i);
         press(0, 2, 2);
      end
      push(K_REJ, 995);
      press(1, 2, 2);
      for (int i = 996; i <= 999; i++) begin
         push(K_COIN, i);
         press(0, 2, 2);
      end
      push(K_REJ, 999);
      press(0, 2, 2);
      drain(100);

      // cancel the full balance: 99 tens then 9 ones
      for (int i = 1; i <= 99; i++) begin
         push(K_COIN, 999 - 10 * i);
         push(K_CHG10, (i == 1) ? 1 : 3);
      end
      for (int j = 8; j >= 0; j--) begin
         push(K_COIN, j);
         push(K_CHG1, 3);
      end
      push(K_IDLE, 3);
      press(5, 2, 2);
      drain(1500);

      // cancel beats coin_ten in the same cycle; buy_one during CHANGE is dropped
      push(K_COIN, 10);
      press(1, 2, 2);
      drain(20);
      push(K_COIN, 0); push(K_CHG10, 1); push(K_IDLE, 3);
      @(negedge clk);
      in_vec[5] = 1'b1;
      in_vec[1] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      in_vec[2] = 1'b1;
      repeat (4) @(negedge clk);
      in_vec = 6'd0;
      drain(50);

      // reset during the second VEND cycle
      push(K_COIN, 10);
      press(1, 2, 2);
      drain(20);
      push(K_COIN, 8); push(K_BUY, 8);
      @(negedge clk);
      in_vec[2] = 1'b1;
      wait_out(0, "vend_start");
      mid_reset("rst_vend");
      drain(20);
      push(K_COIN, 1);
      press(0, 2, 2);
      drain(20);

      // reset during a CHANGE gap
      push(K_COIN, 11); press(1, 2, 2);
      push(K_COIN, 12); press(0, 2, 2);
      drain(20);
      push(K_COIN, 2); push(K_CHG10, 1);
      @(negedge clk);
      in_vec[4] = 1'b1;
      wait_out(1, "chg_start");
      mid_reset("rst_chg");
      drain(20);
      push(K_COIN, 1);
      press(0, 2, 2);
      drain(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Sequencing controller for the vending-machine credit datapath.
- Converts raw coin and button levels into single-cycle events and holds the credit balance.
- Arbitrates simultaneous requests and runs purchase and change-return sequences.
- Sits between the front-panel inputs and the dispense/change actuators, and drives the balance display value.

Parameters:
- PRICE_ONE, 2, price of product 1 in yuan.
- PRICE_TWO, 5, price of product 2 in yuan.
- MAX_BAL, 999, maximum credit; must be < 1024.
- VEND_CYCLES, 4, number of cycles a dispense output is held high.
- PULSE_GAP, 2, number of low cycles after each change pulse.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- coin_one  in  1  raw level; 1-yuan coin inserted.
- coin_ten  in  1  raw level; 10-yuan coin inserted.
- buy_one  in  1  raw level; product 1 request.
- buy_two  in  1  raw level; product 2 request.
- get_ind  in  1  raw level; return-change request.
- cancle_flag  in  1  raw level; cancel, refund credit.
- coin_val  out  10  current balance in yuan.
- buy_flag  out  1  1-cycle pulse when a purchase is accepted.
- disp_one  out  1  dispense product 1, high for VEND_CYCLES cycles.
- disp_two  out  1  dispense product 2, high for VEND_CYCLES cycles.
- chg_ten  out  1  1-cycle pulse per 10-yuan change coin.
- chg_one  out  1  1-cycle pulse per 1-yuan change coin.
- coin_rej  out  1  1-cycle pulse; coin refused (would exceed MAX_BAL).
- short_err  out  1  1-cycle pulse; buy refused (insufficient credit).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - coin_val=0; state=IDLE.
  - All pulse, dispense and busy outputs = 0.
  - Synchronizer and edge-detect flops cleared to 0.
  - Reset asserted mid-VEND or mid-CHANGE aborts immediately; no residual pulses; remaining credit is lost.
- Input conditioning:
  - Each raw input passes through a 2-flop synchronizer, then a rising-edge detector, giving one event per low-to-high transition.
  - A level held high produces one event only.
  - If clk edge k is the first to sample an input high, the event is active in cycle k+2, and the resulting state/coin_val/pulse changes are registered at edge k+3.
- Arbitration: only one event is serviced per cycle, in this priority order:
  - cancle_flag > get_ind > buy_two > buy_one > coin_ten > coin_one.
  - Lower-priority events in the same cycle are discarded, not queued.
- States: IDLE, VEND, CHANGE. Events arriving in VEND or CHANGE are discarded.
- IDLE, coin event:
  - If coin_val + 1 (or + 10) <= MAX_BAL, coin_val is incremented by that amount.
  - Otherwise coin_val is unchanged and coin_rej pulses.
- IDLE, buy event:
  - If coin_val >= price: coin_val -= price, buy_flag pulses, state -> VEND.
    - The selected disp_x is high for exactly VEND_CYCLES cycles, starting the cycle after the accepting edge.
    - State returns to IDLE on the edge that drops disp_x.
  - If coin_val < price: short_err pulses; coin_val and state are unchanged.
  - Credit exactly equal to the price is accepted; coin_val becomes 0.
- IDLE, get_ind or cancle_flag event:
  - If coin_val == 0: no action, no busy.
  - Otherwise state -> CHANGE.
- CHANGE sequence:
  - While coin_val >= 10: chg_ten pulses for 1 cycle and coin_val -= 10 on the same edge, followed by PULSE_GAP low cycles.
  - Then, while coin_val > 0: chg_one pulses with coin_val -= 1, followed by PULSE_GAP low cycles.
  - State returns to IDLE at the end of the final gap.
  - Total change pulses = floor(bal/10) + (bal mod 10).
- Width rules:
  - coin_val is unsigned 10-bit.
  - Subtraction happens only after a compare, so coin_val never underflows.
  - Addition is checked against MAX_BAL, so coin_val never wraps.

Test Plan:
1. Reset, then coin_one x3 and coin_ten x1 (each held 4 clk, low 4 clk) -> coin_val steps 1, 2, 3, 13; no coin_rej.
2. From 13: buy_two, buy_two, buy_one ->
   - first buy_two: coin_val=8, buy_flag pulse, disp_two high 4 cycles;
   - second buy_two: coin_val=3, disp_two high 4 cycles;
   - buy_one: coin_val=1, disp_one high 4 cycles.
   Then buy_two at 1 -> short_err pulse, coin_val stays 1.
3. coin_val=23, get_ind -> exactly 2 chg_ten then 3 chg_one pulses, each followed by 2 low cycles; coin_val 23 -> 0; busy drops after last gap.
4. coin_val=995, coin_ten -> coin_rej pulse, coin_val 995; then coin_one x4 -> coin_val 999; further coin_one -> coin_rej.
5. cancle_flag and coin_ten rising in the same cycle with coin_val=10 -> one chg_ten pulse, coin_ten ignored, final coin_val=0. During CHANGE, a buy_one pulse -> ignored.
6. reset pulled low during the 2nd cycle of VEND, and separately during a CHANGE gap -> all outputs 0 asynchronously, coin_val=0. After release, coin_one -> coin_val=1.
